// File: rtl/number_pkg.sv
// Constants and FSM state type shared by the BITS literal number encoder and decoder.
package number_pkg;

  localparam int GROUP_W    = 5;
  localparam int NIBBLE_W   = 4;
  localparam int MAX_GROUPS = 16;
  localparam int WORD_W     = 80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIZE = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } encState_t;

endpackage

// File: rtl/number_group_pack.sv
// Combinational packer: finds the highest nonzero nibble and lays the used nibbles
// out as left-justified {continue, nibble} groups.
module number_group_pack
  import number_pkg::*;
(
  input  logic [MAX_GROUPS*NIBBLE_W-1:0] numReg,
  output logic [WORD_W-1:0]              packedWord,
  output logic [4:0]                     numGroups
);

  logic [MAX_GROUPS*NIBBLE_W-1:0] aligned;

  // Shifting the value up puts the most significant used nibble at the top,
  // so group i always takes nibble i of the aligned value.
  always_comb begin
    numGroups = 5'd1;
    for (int j = 1; j < MAX_GROUPS; j++) begin
      if (numReg[j*NIBBLE_W +: NIBBLE_W] != '0) begin
        numGroups = 5'(j + 1);
      end
    end
    aligned = numReg << (NIBBLE_W * (MAX_GROUPS - int'(numGroups)));
    packedWord = '0;
    for (int i = 0; i < MAX_GROUPS; i++) begin
      if (i < int'(numGroups)) begin
        packedWord[WORD_W-1-GROUP_W*i -: GROUP_W] =
          {(i != int'(numGroups) - 1),
           aligned[MAX_GROUPS*NIBBLE_W-1-NIBBLE_W*i -: NIBBLE_W]};
      end
    end
  end

endmodule

// File: rtl/number_encoder.sv
// BITS literal encoder: sizes and packs a number, then streams the packed groups
// MSB-first over a valid/ready handshake.
module number_encoder #(
  parameter int NUM_W  = 64,
  parameter int WORD_W = 5 * NUM_W / 4,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  number,
  output logic              busy,
  output logic [WORD_W-1:0] bitsWord,
  output logic [4:0]        numGroups,
  output logic              bitValid,
  output logic              bitOut,
  input  logic              bitReady,
  output logic              done
);

  import number_pkg::*;

  encState_t          state;
  encState_t          nextState;
  logic [NUM_W-1:0]   numReg;
  logic [WORD_W-1:0]  shiftReg;
  logic [CNT_W-1:0]   bitCnt;
  logic [WORD_W-1:0]  packWord;
  logic [4:0]         packGroups;

  number_group_pack u_pack (
    .numReg     (numReg),
    .packedWord (packWord),
    .numGroups  (packGroups)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = ST_SIZE;
      ST_SIZE: nextState = ST_EMIT;
      ST_EMIT: if (bitReady && bitCnt == CNT_W'(1)) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // bitsWord/numGroups only change at the end of SIZE, so they stay readable after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      numReg    <= '0;
      bitsWord  <= '0;
      numGroups <= '0;
      shiftReg  <= '0;
      bitCnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) numReg <= number;
        ST_SIZE: begin
          bitsWord  <= packWord;
          numGroups <= packGroups;
          shiftReg  <= packWord;
          bitCnt    <= CNT_W'(GROUP_W * int'(packGroups));
        end
        ST_EMIT: if (bitReady) begin
          shiftReg <= shiftReg << 1;
          bitCnt   <= bitCnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    bitValid = (state == ST_EMIT);
    bitOut   = (state == ST_EMIT) && shiftReg[WORD_W-1];
    done     = (state == ST_DONE);
  end

endmodule

// File: tb/tb_number_encoder.sv
// Self-checking bench for number_encoder: directed table, randomized numbers against
// a nibble-walking reference model, stall/ignore-start and mid-stream reset sequences.
module tb_number_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] number;
  logic        busy;
  logic [79:0] bitsWord;
  logic [4:0]  numGroups;
  logic        bitValid;
  logic        bitOut;
  logic        bitReady;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit gotBits[$];

  typedef struct {
    logic [63:0] num;
    int          readyMode;
    bit          pulseStart;
    int          expGroups;
    logic [79:0] expWord;
  } vec_t;

  vec_t vecs[5];

  number_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .number    (number),
    .busy      (busy),
    .bitsWord  (bitsWord),
    .numGroups (numGroups),
    .bitValid  (bitValid),
    .bitOut    (bitOut),
    .bitReady  (bitReady),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count nibbles by repeated division, then emit groups MS nibble first.
  task automatic modelEncode(input logic [63:0] n, output int ng, output logic [79:0] w);
    logic [63:0] v;
    logic [4:0]  grp;
    int          pos;
    ng = 1;
    v  = n >> 4;
    while (v != 0) begin
      ng++;
      v = v >> 4;
    end
    w   = '0;
    pos = 79;
    for (int g = ng - 1; g >= 0; g--) begin
      grp = {(g != 0), 4'((n >> (4 * g)) & 64'hf)};
      for (int b = 4; b >= 0; b--) begin
        w[pos] = grp[b];
        pos--;
      end
    end
  endtask

  // readyMode: 0 = always ready, 1 = toggle each cycle, 2 = random.
  task automatic applyStimulus(input logic [63:0] num, input int readyMode, input bit pulseStart,
                               input int expGroups, input logic [79:0] expWord);
    int          lat;
    bit          prevStall;
    bit          prevBit;
    logic [79:0] gotWord;
    gotBits.delete();
    prevStall = 1'b0;
    prevBit   = 1'b0;
    number    = num;
    start     = 1'b1;
    bitReady  = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    lat = 1;
    while (!done && lat < 400) begin
      start = 1'b0;
      case (readyMode)
        0:       bitReady = 1'b1;
        1:       bitReady = lat[0];
        default: bitReady = 1'($urandom % 2);
      endcase
      if (bitValid && prevStall) checkOutput("stallHold", bitOut, prevBit);
      if (bitValid && bitReady) gotBits.push_back(bitOut);
      prevStall = bitValid && !bitReady;
      prevBit   = bitOut;
      if (pulseStart && lat == 4) begin
        start  = 1'b1;
        number = ~num;
      end
      stepCycle();
      lat++;
    end
    start = 1'b0;
    checkOutput("doneSeen", done, 1);
    checkOutput("busyAtDone", busy, 1);
    checkOutput("validAtDone", bitValid, 0);
    if (readyMode == 0) checkOutput("doneLatency", lat, 5 * expGroups + 2);
    checkOutput("numGroups", numGroups, expGroups);
    checkOutput("bitsWord", bitsWord, expWord);
    gotWord = '0;
    for (int i = 0; i < gotBits.size() && i < 80; i++) gotWord[79 - i] = gotBits[i];
    checkOutput("serialCount", gotBits.size(), 5 * expGroups);
    checkOutput("serialBits", gotWord, expWord);
    bitReady = 1'b1;
    stepCycle();
    checkOutput("donePulseOne", done, 0);
    checkOutput("idleAfterDone", busy, 0);
    stepCycle();
    checkOutput("startNotQueued", busy, 0);
    checkOutput("bitsWordHeld", bitsWord, expWord);
  endtask

  initial begin
    int          ng;
    logic [79:0] w;
    logic [63:0] rn;

    vecs[0] = '{64'h0,                  0, 1'b0, 1,  80'h0};
    vecs[1] = '{64'hf,                  0, 1'b0, 1,  80'h7800_0000_0000_0000_0000};
    vecs[2] = '{64'h123,                0, 1'b0, 3,  80'h8c86_0000_0000_0000_0000};
    vecs[3] = '{64'h1fff_ffff_ffff_ffff, 0, 1'b0, 16, 80'h8fff_ffff_ffff_ffff_ffef};
    vecs[4] = '{64'h10,                 1, 1'b1, 2,  80'h8800_0000_0000_0000_0000};

    reset    = 1'b1;
    start    = 1'b0;
    number   = '0;
    bitReady = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstWord", bitsWord, 0);
    checkOutput("rstGroups", numGroups, 0);
    checkOutput("rstValid", bitValid, 0);
    checkOutput("rstBitOut", bitOut, 0);
    checkOutput("rstDone", done, 0);
    reset = 1'b0;
    stepCycle();

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k].num, vecs[k].readyMode, vecs[k].pulseStart,
                    vecs[k].expGroups, vecs[k].expWord);
    end

    for (int k = 0; k < 30; k++) begin
      rn = {$urandom, $urandom};
      rn = rn >> (4 * $urandom_range(0, 16));
      if (k % 5 == 0) rn[4 * $urandom_range(0, 7) +: 4] = 4'h0;
      modelEncode(rn, ng, w);
      applyStimulus(rn, (k % 3 == 0) ? 0 : 2, 1'b0, ng, w);
    end

    number   = 64'h123;
    start    = 1'b1;
    bitReady = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int c = 0; c < 5; c++) stepCycle();
    checkOutput("midEmitValid", bitValid, 1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortWord", bitsWord, 0);
    checkOutput("abortGroups", numGroups, 0);
    checkOutput("abortValid", bitValid, 0);
    checkOutput("abortBitOut", bitOut, 0);
    checkOutput("abortDone", done, 0);
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      checkOutput("noDoneAfterAbort", done, 0);
    end
    applyStimulus(64'hf, 0, 1'b0, 1, 80'h7800_0000_0000_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
